// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Loadable BCD up/down counter with a programmable modulus (0..MAX_VALUE).
// Used across the timekeeping datapath; tc of one counter drives tick of the
// next one to build cascades (seconds -> minutes -> hours).
//
// Parameters:
//   DIGITS     number of BCD digits (1..4)
//   MAX_VALUE  terminal count in decimal (1..10^DIGITS-1)
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   tick       single-cycle count strobe, qualified by en
//   en         run enable; 0 freezes the count and suppresses tc
//   up         direction, 1 = up, 0 = down
//   load       synchronous load request (wins over tick)
//   load_value BCD value to load, digit 0 in [3:0]
//   value      registered BCD count
//   tc         registered one-cycle terminal-count pulse
//   zero       high while value == 0
//   load_err   registered one-cycle pulse for a rejected load
//
// Configuration macro:
//   BCD_CNT_SATURATE_EN  when defined, the count saturates at 0 / MAX_VALUE
//                        instead of wrapping; tc pulses on reaching the bound.
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int DIGITS    = 2,
  parameter int MAX_VALUE = 59
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   value,
  output logic                  tc,
  output logic                  zero,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  // Decimal-to-BCD conversion of the modulus, evaluated at elaboration.
  function automatic logic [W-1:0] toBcd(input int v);
    logic [W-1:0] r;
    int           rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = toBcd(MAX_VALUE);

  // Ripple increment: a digit steps only while every lower digit was 9.
  function automatic logic [W-1:0] bcdInc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple decrement: a digit steps only while every lower digit was 0.
  function automatic logic [W-1:0] bcdDec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic allDigitsBcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  logic [W-1:0] value_q, value_d;
  logic         tc_q, tc_d;
  logic         loadErr_q, loadErr_d;
  logic [W-1:0] incVal;
  logic [W-1:0] decVal;
  logic         loadOk;
  logic         atMax;
  logic         atZero;

  assign incVal = bcdInc(value_q);
  assign decVal = bcdDec(value_q);
  assign atMax  = (value_q == MAX_BCD);
  assign atZero = (value_q == '0);

  // With every digit in 0..9, the packed BCD vector orders exactly like the
  // decimal number, so a plain unsigned compare checks the modulus bound.
  assign loadOk = allDigitsBcd(load_value) && (load_value <= MAX_BCD);

  always_comb begin
    value_d   = value_q;
    tc_d      = 1'b0;
    loadErr_d = 1'b0;
    if (load) begin
      if (loadOk) begin
        value_d = load_value;
      end else begin
        loadErr_d = 1'b1;
      end
    end else if (tick && en) begin
      if (up) begin
`ifdef BCD_CNT_SATURATE_EN
        if (!atMax) begin
          value_d = incVal;
          tc_d    = (incVal == MAX_BCD);
        end
`else
        if (atMax) begin
          value_d = '0;
          tc_d    = 1'b1;
        end else begin
          value_d = incVal;
        end
`endif
      end else begin
`ifdef BCD_CNT_SATURATE_EN
        if (!atZero) begin
          value_d = decVal;
          tc_d    = (decVal == '0);
        end
`else
        if (atZero) begin
          value_d = MAX_BCD;
          tc_d    = 1'b1;
        end else begin
          value_d = decVal;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_q   <= '0;
      tc_q      <= 1'b0;
      loadErr_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      tc_q      <= tc_d;
      loadErr_q <= loadErr_d;
    end
  end

  assign value    = value_q;
  assign tc       = tc_q;
  assign load_err = loadErr_q;
  assign zero     = atZero;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Directed bench for bcd_updown_counter: one DIGITS=2/MAX=59 instance for the
// single-counter behaviour plus a 60 x 24 cascade (MAX 59 feeding MAX 23).
// Inputs change 1 time unit after the rising edge and outputs are sampled at
// the same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

  logic       clk;
  logic       reset_n;
  logic       tick;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] value;
  logic       tc;
  logic       zero;
  logic       load_err;

  logic       casTick;
  logic       casEn;
  logic [7:0] minValue;
  logic       minTc;
  logic       minZero;
  logic       minErr;
  logic [7:0] hrValue;
  logic       hrTc;
  logic       hrZero;
  logic       hrErr;

  int checksTotal  = 0;
  int checksPassed = 0;

  bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(59)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .value      (value),
    .tc         (tc),
    .zero       (zero),
    .load_err   (load_err)
  );

  bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(59)) minCnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (casTick),
    .en         (casEn),
    .up         (1'b1),
    .load       (1'b0),
    .load_value (8'h00),
    .value      (minValue),
    .tc         (minTc),
    .zero       (minZero),
    .load_err   (minErr)
  );

  bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(23)) hrCnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (minTc),
    .en         (casEn),
    .up         (1'b1),
    .load       (1'b0),
    .load_value (8'h00),
    .value      (hrValue),
    .tc         (hrTc),
    .zero       (hrZero),
    .load_err   (hrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] toBcd2(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checksTotal++;
    if (obs === exp) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs; strobes drop again afterwards.
  task automatic applyStimulus(input logic t, input logic u, input logic l, input logic [7:0] lv);
    tick       = t;
    up         = u;
    load       = l;
    load_value = lv;
    @(posedge clk);
    #1;
    tick = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    int tcCount;
    int hrTcCount;

    reset_n    = 1'b0;
    tick       = 1'b0;
    en         = 1'b1;
    up         = 1'b1;
    load       = 1'b0;
    load_value = 8'h00;
    casTick    = 1'b0;
    casEn      = 1'b1;

    // Reset held with tick active.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("reset value", 16'(value), 16'h00);
      checkOutput("reset zero", 16'(zero), 16'h1);
      checkOutput("reset tc", 16'(tc), 16'h0);
      checkOutput("reset load_err", 16'(load_err), 16'h0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("hold value", 16'(value), 16'h00);
      checkOutput("hold tc", 16'(tc), 16'h0);
    end

`ifndef BCD_CNT_SATURATE_EN
    // Up through a full wrap: 00..59 then 00 with one tc.
    tcCount = 0;
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("up value", 16'(value), 16'(toBcd2(i % 60)));
      checkOutput("up tc", 16'(tc), (i == 60) ? 16'h1 : 16'h0);
      if (tc) tcCount++;
    end
    checkOutput("up zero after wrap", 16'(zero), 16'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("up tc single", 16'(tc), 16'h0);
    checkOutput("up tc count", 16'(tcCount), 16'd1);

    // Down with borrow and wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h10);
    checkOutput("load 10", 16'(value), 16'h10);
    checkOutput("load 10 err", 16'(load_err), 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("down borrow", 16'(value), 16'h09);
    checkOutput("down zero flag", 16'(zero), 16'h0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("down to 00", 16'(value), 16'h00);
    checkOutput("down 00 tc", 16'(tc), 16'h0);
    checkOutput("down 00 zero", 16'(zero), 16'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("down wrap value", 16'(value), 16'h59);
    checkOutput("down wrap tc", 16'(tc), 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("down wrap tc drop", 16'(tc), 16'h0);
`else
    // Saturation at the upper and lower bounds.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h57);
    checkOutput("sat load 57", 16'(value), 16'h57);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("sat up value", 16'(value), (i == 1) ? 16'h58 : 16'h59);
      checkOutput("sat up tc", 16'(tc), (i == 2) ? 16'h1 : 16'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("sat leave bound", 16'(value), 16'h58);
    checkOutput("sat leave tc", 16'(tc), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h01);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("sat down to 0", 16'(value), 16'h00);
    checkOutput("sat down tc", 16'(tc), 16'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("sat hold 0", 16'(value), 16'h00);
    checkOutput("sat hold 0 tc", 16'(tc), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h59);
`endif

    // Load validation, value 59 beforehand.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A);
    checkOutput("bad digit value", 16'(value), 16'h59);
    checkOutput("bad digit err", 16'(load_err), 16'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("err pulse width", 16'(load_err), 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h60);
    checkOutput("over max value", 16'(value), 16'h59);
    checkOutput("over max err", 16'(load_err), 16'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
    checkOutput("load 00", 16'(value), 16'h00);
    checkOutput("load 00 err", 16'(load_err), 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h59);
    checkOutput("load 59", 16'(value), 16'h59);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h45);
    checkOutput("load+tick value", 16'(value), 16'h45);
    checkOutput("load+tick tc", 16'(tc), 16'h0);
    checkOutput("load+tick err", 16'(load_err), 16'h0);

    // Enable gating, back-to-back ticks and a direction change.
    en = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("en=0 value", 16'(value), 16'h45);
    en = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("b2b up 1", 16'(value), 16'h46);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("b2b up 2", 16'(value), 16'h47);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("dir change", 16'(value), 16'h46);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h39);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("digit carry", 16'(value), 16'h40);

    // Held load blocks counting.
    load       = 1'b1;
    load_value = 8'h12;
    tick       = 1'b1;
    up         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("held load", 16'(value), 16'h12);
    load = 1'b0;
    tick = 1'b0;

    // Reset on the same edge as a wrapping tick.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h59);
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    reset_n = 1'b1;
    checkOutput("mid reset value", 16'(value), 16'h00);
    checkOutput("mid reset tc", 16'(tc), 16'h0);
    checkOutput("mid reset zero", 16'(zero), 16'h1);

`ifndef BCD_CNT_SATURATE_EN
    // 60 x 24 cascade, with a freeze after 125 ticks.
    hrTcCount = 0;
    casEn     = 1'b1;
    for (int i = 0; i < 125; i++) begin
      casTick = 1'b1;
      @(posedge clk);
      #1;
      if (hrTc) hrTcCount++;
    end
    checkOutput("cascade min 05", 16'(minValue), 16'h05);
    checkOutput("cascade hr 02", 16'(hrValue), 16'h02);
    casEn = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("freeze min", 16'(minValue), 16'h05);
    checkOutput("freeze hr", 16'(hrValue), 16'h02);
    casEn = 1'b1;
    for (int i = 0; i < 1315; i++) begin
      @(posedge clk);
      #1;
      if (hrTc) hrTcCount++;
    end
    casTick = 1'b0;
    checkOutput("cascade min 00", 16'(minValue), 16'h00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (hrTc) hrTcCount++;
    end
    checkOutput("cascade hr 00", 16'(hrValue), 16'h00);
    checkOutput("cascade hr tc count", 16'(hrTcCount), 16'd1);
`endif

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
